// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master, MSB first, all pin and host outputs registered
// One FSM walks SETUP/HIGH/LOW/HOLD/GAP; each state visit lasts CLK_DIV clocks.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rxData,
  output logic             cs,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t           state;
  logic [7:0]       half_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_next;
  logic [WIDTH-1:0] rx_shift;
  logic             half_end;

  assign half_end = (half_cnt == DIV_LAST);
  // Once the last bit has been shifted out tx_next is all zero, so mosi drops to 0.
  assign tx_next  = tx_shift << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rxData   <= '0;
      cs       <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE)
        half_cnt <= half_end ? 8'd0 : half_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            busy     <= 1'b1;
            cs       <= 1'b0;
            tx_shift <= txData;
            mosi     <= txData[WIDTH-1];
            rx_shift <= '0;
            bit_cnt  <= '0;
            half_cnt <= '0;
          end
        end
        SETUP: begin
          if (half_end) begin
            state    <= HIGH;
            sck      <= 1'b1;
            rx_shift <= WIDTH'({rx_shift, miso});
          end
        end
        HIGH: begin
          if (half_end) begin
            state    <= LOW;
            sck      <= 1'b0;
            tx_shift <= tx_next;
            mosi     <= tx_next[WIDTH-1];
          end
        end
        LOW: begin
          if (half_end) begin
            if (bit_cnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              state    <= HIGH;
              bit_cnt  <= bit_cnt + 1'b1;
              sck      <= 1'b1;
              rx_shift <= WIDTH'({rx_shift, miso});
            end
          end
        end
        HOLD: begin
          if (half_end) begin
            state  <= GAP;
            cs     <= 1'b1;
            done   <= 1'b1;
            rxData <= rx_shift;
          end
        end
        GAP: begin
          if (half_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
